// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one fixed-latency pipelined signed 32x32 multiplier among
// N_REQ valid/ready requesters and routes each 64-bit product back by tag.
// Build option: define MULT_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// highest) instead of round robin.

module mult_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    output logic                 mult_valid_in,
    input  logic [63:0]          mult_result,
    input  logic                 mult_valid_out,
    output logic [N_REQ*64-1:0]  res_data,
    output logic [N_REQ-1:0]     res_valid,
    output logic                 busy,
    output logic                 err_mismatch
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned LAST  = MULT_LATENCY - 1;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             transfer;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [IDX_W-1:0] issue_idx;

    logic             tag_v   [MULT_LATENCY];
    logic [IDX_W-1:0] tag_idx [MULT_LATENCY];

`ifndef MULT_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
    int unsigned      cand;
`endif

    // Pick the requester to grant this cycle.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
`else
        cand = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end
`endif
        for (int k = 0; k < N_REQ; k++) begin
            grant[k] = grant_any && (grant_idx == IDX_W'(k));
        end
    end

    // Handshake and operand selection; ready never looks at the multiplier side.
    always_comb begin
        req_ready = grant & {N_REQ{enable & ~reset}};
        transfer  = grant_any & enable & ~reset;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_a = req_a[k*32 +: 32];
                sel_b = req_b[k*32 +: 32];
            end
        end
    end

`ifndef MULT_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves just past the last granted requester.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            if (grant_idx == IDX_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

    // Issue register feeding the multiplier.
    always_ff @(posedge clock) begin
        if (reset) begin
            mult_valid_in <= 1'b0;
            mult_a        <= '0;
            mult_b        <= '0;
            issue_idx     <= '0;
        end else begin
            mult_valid_in <= transfer;
            if (transfer) begin
                mult_a    <= sel_a;
                mult_b    <= sel_b;
                issue_idx <= grant_idx;
            end
        end
    end

    // Tag pipeline shadows the multiplier; free-running regardless of enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < MULT_LATENCY; s++) begin
                tag_v[s]   <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            tag_v[0]   <= mult_valid_in;
            tag_idx[0] <= issue_idx;
            for (int s = 1; s < MULT_LATENCY; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // Return path: route the product by tag and flag valid disagreement.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_data     <= '0;
            res_valid    <= '0;
            err_mismatch <= 1'b0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                res_valid[k] <= 1'b0;
                if (tag_v[LAST] && (tag_idx[LAST] == IDX_W'(k))) begin
                    res_valid[k]         <= 1'b1;
                    res_data[k*64 +: 64] <= mult_result;
                end
            end
            if (mult_valid_out != tag_v[LAST]) begin
                err_mismatch <= 1'b1;
            end
        end
    end

    // Busy while anything is in flight.
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MULT_LATENCY; s++) begin
            busy = busy | tag_v[s];
        end
    end

endmodule
